hazard_scheduler: RTL and testbench

- Pipeline sequencing controller for the vector ASIP fetch/decode/execute/memory/writeback pipeline.
- Tracks in-flight register writes in a scoreboard and stalls fetch/decode on read-after-write hazards.
- Inserts bubbles into the decode-execute pipe and flushes younger stages when execute redirects the PC.
- Sits beside the pipe registers and drives their hold/flush controls; no datapath.

---
 rtl/hazard_scheduler.sv | 166 ++++++++++++++++
 tb/tb_hazard_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scheduler.sv
// hazard_scheduler: RAW scoreboard, stall/bubble and branch-flush sequencer
// for the fetch/decode/execute/memory/writeback pipe. No datapath.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   dec_valid         decode holds a real instruction
//   dec_rSel1/2       source registers, dec_use1/2 source-read enables
//   dec_regWrEn       decode instruction writes dec_regToWrite
//   dec_isLoad        write data comes from memory
//   ex_pcWrEn         execute resolved a taken PC write
//   stall_f           hold PC and fetch-decode pipe
//   bubble_d          load NOP into decode-execute pipe
//   flush_fd/flush_de clear fetch-decode / decode-execute pipe
//   busy              registered: any slot valid or FSM not in RUN
//   stall_count       saturating hazard-stall cycle count
//   flush_count       saturating flush cycle count
//
// Build option: FORWARD_EN (defined: only load-use hits in slot0 stall).
module hazard_scheduler #(
    parameter int selBits     = 4,
    parameter int trackDepth  = 3,
    parameter int flushCycles = 2,
    parameter int cntWidth    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dec_valid,
    input  logic [selBits-1:0]  dec_rSel1,
    input  logic [selBits-1:0]  dec_rSel2,
    input  logic                dec_use1,
    input  logic                dec_use2,
    input  logic                dec_regWrEn,
    input  logic [selBits-1:0]  dec_regToWrite,
    input  logic                dec_isLoad,
    input  logic                ex_pcWrEn,
    output logic                stall_f,
    output logic                bubble_d,
    output logic                flush_fd,
    output logic                flush_de,
    output logic                busy,
    output logic [cntWidth-1:0] stall_count,
    output logic [cntWidth-1:0] flush_count
);

    localparam int FcW = (flushCycles > 1) ? $clog2(flushCycles) : 1;
    localparam logic [FcW-1:0] FC_LOAD = FcW'(flushCycles - 1);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t state;
    state_t state_nx;
    logic [FcW-1:0] fcnt;
    logic [FcW-1:0] fcnt_nx;

    // slot0 = EX, slot1 = MEM, slot(trackDepth-1) = WB
    logic [trackDepth-1:0] slot_vld;
    logic [trackDepth-1:0] slot_ld;
    logic [selBits-1:0]    slot_reg [trackDepth];
    logic [trackDepth-1:0] vld_nx;

    logic hit;
    logic running;
    logic flushing;
    logic hazard;
    logic issue;
    logic busy_nx;

    // Only slot0's load flag matters with bypassing; without it none do.
    logic unused_ld;
    assign unused_ld = ^slot_ld;

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < trackDepth; i++) begin
            if (slot_vld[i] &&
                ((dec_use1 && slot_reg[i] == dec_rSel1) ||
                 (dec_use2 && slot_reg[i] == dec_rSel2))) begin
`ifdef FORWARD_EN
                if (i == 0 && slot_ld[0]) begin
                    hit = 1'b1;
                end
`else
                hit = 1'b1;
`endif
            end
        end
    end

    assign running  = (state == RUN);
    assign flushing = !rst && (ex_pcWrEn || state == FLUSH);
    assign hazard   = !rst && dec_valid && running && hit;

    // A redirect makes the stalled instruction dead, so flush wins.
    assign stall_f  = hazard && !flushing;
    assign bubble_d = stall_f;
    assign flush_fd = flushing;
    assign flush_de = flushing;

    assign issue = !rst && dec_valid && dec_regWrEn && running &&
                   !ex_pcWrEn && !stall_f;

    assign vld_nx  = {slot_vld[trackDepth-2:0], issue};
    assign busy_nx = (|vld_nx) || (state_nx != RUN);

    always_comb begin
        state_nx = state;
        fcnt_nx  = fcnt;
        unique case (state)
            RUN: begin
                if (ex_pcWrEn && flushCycles > 1) begin
                    state_nx = FLUSH;
                    fcnt_nx  = FC_LOAD;
                end
            end
            FLUSH: begin
                if (ex_pcWrEn) begin
                    fcnt_nx = FC_LOAD;
                end else if (fcnt <= FcW'(1)) begin
                    state_nx = RUN;
                    fcnt_nx  = '0;
                end else begin
                    fcnt_nx = fcnt - FcW'(1);
                end
            end
            default: begin
                state_nx = RUN;
                fcnt_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            fcnt        <= '0;
            slot_vld    <= '0;
            slot_ld     <= '0;
            busy        <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
            for (int i = 0; i < trackDepth; i++) begin
                slot_reg[i] <= '0;
            end
        end else begin
            state       <= state_nx;
            fcnt        <= fcnt_nx;
            slot_vld    <= vld_nx;
            slot_ld     <= {slot_ld[trackDepth-2:0], dec_isLoad};
            busy        <= busy_nx;
            slot_reg[0] <= dec_regToWrite;
            for (int i = 1; i < trackDepth; i++) begin
                slot_reg[i] <= slot_reg[i-1];
            end
            if (stall_f && stall_count != '1) begin
                stall_count <= stall_count + cntWidth'(1);
            end
            if (flushing && flush_count != '1) begin
                flush_count <= flush_count + cntWidth'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb_hazard_scheduler: directed table, corner sequences and random stimulus
// checked against a queue-based model of in-flight writes.
`timescale 1ns/1ps
module tb_hazard_scheduler;

`ifdef FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int FC = 2;
    localparam int SAT_MAX = 65535;

    logic clk = 1'b1;
    always #5 clk = ~clk;

    logic       rst, dec_valid, dec_use1, dec_use2;
    logic       dec_regWrEn, dec_isLoad, ex_pcWrEn;
    logic [3:0] dec_rSel1, dec_rSel2, dec_regToWrite;
    logic       stall_f, bubble_d, flush_fd, flush_de, busy;
    logic [15:0] stall_count, flush_count;

    logic       sat_unused_st, sat_unused_bd, sat_unused_ff;
    logic       sat_unused_fd, sat_unused_busy;
    logic [7:0] sat_stall_count, sat_unused_fc;

    hazard_scheduler dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid),
        .dec_rSel1(dec_rSel1), .dec_rSel2(dec_rSel2),
        .dec_use1(dec_use1), .dec_use2(dec_use2),
        .dec_regWrEn(dec_regWrEn), .dec_regToWrite(dec_regToWrite),
        .dec_isLoad(dec_isLoad), .ex_pcWrEn(ex_pcWrEn),
        .stall_f(stall_f), .bubble_d(bubble_d),
        .flush_fd(flush_fd), .flush_de(flush_de), .busy(busy),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    // Narrow-counter copy: reaches saturation in a short run.
    hazard_scheduler #(.cntWidth(8)) dut_sat (
        .clk(clk), .rst(rst), .dec_valid(dec_valid),
        .dec_rSel1(dec_rSel1), .dec_rSel2(dec_rSel2),
        .dec_use1(dec_use1), .dec_use2(dec_use2),
        .dec_regWrEn(dec_regWrEn), .dec_regToWrite(dec_regToWrite),
        .dec_isLoad(dec_isLoad), .ex_pcWrEn(ex_pcWrEn),
        .stall_f(sat_unused_st), .bubble_d(sat_unused_bd),
        .flush_fd(sat_unused_ff), .flush_de(sat_unused_fd),
        .busy(sat_unused_busy),
        .stall_count(sat_stall_count), .flush_count(sat_unused_fc)
    );

    typedef struct packed {
        logic       rst;
        logic       valid;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       u1;
        logic       u2;
        logic       we;
        logic [3:0] wr;
        logic       ld;
        logic       pcw;
    } in_t;

    typedef struct {
        in_t in;
        bit  e_stall;
        bit  e_flush;
        bit  e_busy;
        int  e_scnt;
        int  e_fcnt;
    } vec_t;

    typedef struct {
        logic [3:0] r;
        bit         ld;
        int         age;
    } wr_t;

    int nvec = 0;
    int nerr = 0;

    // model state
    wr_t q[$];
    int  fl_left = 0;
    int  m_scnt = 0, m_fcnt = 0;
    bit  m_stall, m_flush, m_busy;

    // sampled DUT values
    logic [3:0]  o_ctl;
    logic        r_busy;
    logic [15:0] r_scnt, r_fcnt;
    logic [7:0]  r_sat;

    vec_t vt[$];

    function automatic in_t mk(bit r, bit v, int s1, int s2, bit u1,
                               bit u2, bit we, int wr, bit ld, bit pcw);
        in_t x;
        x.rst = r; x.valid = v; x.s1 = 4'(s1); x.s2 = 4'(s2);
        x.u1 = u1; x.u2 = u2; x.we = we; x.wr = 4'(wr);
        x.ld = ld; x.pcw = pcw;
        return x;
    endfunction

    task automatic add(input in_t in, input bit es, input bit ef,
                       input bit eb, input int sc, input int fc);
        vec_t v;
        v.in = in; v.e_stall = es; v.e_flush = ef;
        v.e_busy = eb; v.e_scnt = sc; v.e_fcnt = fc;
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural model: a list of in-flight writes aged once per cycle.
    task automatic model_step(input in_t in);
        bit hit, haz, iss;
        if (in.rst) begin
            q.delete();
            fl_left = 0; m_scnt = 0; m_fcnt = 0;
            m_stall = 0; m_flush = 0; m_busy = 0;
            return;
        end
        hit = 0;
        foreach (q[k]) begin
            if ((in.u1 && q[k].r == in.s1) || (in.u2 && q[k].r == in.s2))
                if (!FWD || (q[k].age == 0 && q[k].ld)) hit = 1;
        end
        haz = in.valid && fl_left == 0 && hit;
        m_flush = in.pcw || fl_left > 0;
        m_stall = haz && !m_flush;
        iss = in.valid && in.we && !m_stall && fl_left == 0 && !in.pcw;
        foreach (q[k]) q[k].age++;
        for (int k = q.size() - 1; k >= 0; k--)
            if (q[k].age >= 3) q.delete(k);
        if (iss) q.push_back('{r: in.wr, ld: in.ld, age: 0});
        if (in.pcw) fl_left = FC - 1;
        else if (fl_left > 0) fl_left--;
        if (m_stall && m_scnt < SAT_MAX) m_scnt++;
        if (m_flush && m_fcnt < SAT_MAX) m_fcnt++;
        m_busy = q.size() > 0 || fl_left > 0;
    endtask

    task automatic drive(input in_t in);
        rst = in.rst; dec_valid = in.valid;
        dec_rSel1 = in.s1; dec_rSel2 = in.s2;
        dec_use1 = in.u1; dec_use2 = in.u2;
        dec_regWrEn = in.we; dec_regToWrite = in.wr;
        dec_isLoad = in.ld; ex_pcWrEn = in.pcw;
        model_step(in);
        @(negedge clk);
        o_ctl = {stall_f, bubble_d, flush_fd, flush_de};
        @(posedge clk);
        #1;
        r_busy = busy; r_scnt = stall_count;
        r_fcnt = flush_count; r_sat = sat_stall_count;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, " ctl"}, 32'(o_ctl),
            32'({m_stall, m_stall, m_flush, m_flush}));
        chk({tag, " busy"}, 32'(r_busy), 32'(m_busy));
        chk({tag, " stall_count"}, 32'(r_scnt), 32'(m_scnt));
        chk({tag, " flush_count"}, 32'(r_fcnt), 32'(m_fcnt));
    endtask

    initial begin : main
        in_t idle, rd3, pcw, wr1, rd1, ri;
        int  s;
        string tg;

        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rd3  = mk(0, 1, 3, 0, 1, 0, 0, 0, 0, 0);
        pcw  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        s    = FWD ? 1 : 3;

        // reset and idle
        add(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0);
        add(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(idle, 0, 0, 0, 0, 0);
        // load to r3, then reads of r3
        add(mk(0, 1, 0, 0, 0, 0, 1, 3, 1, 0), 0, 0, 1, 0, 0);
        add(rd3, 1, 0, 1, 1, 0);
        add(rd3, !FWD, 0, 1, FWD ? 1 : 2, 0);
        add(rd3, !FWD, 0, 0, s, 0);
        add(rd3, 0, 0, 0, s, 0);
        // single branch pulse
        add(pcw, 0, 1, 1, s, 1);
        add(idle, 0, 1, 0, s, 2);
        add(idle, 0, 0, 0, s, 2);
        // writes offered during flush are dropped
        add(mk(0, 1, 0, 0, 0, 0, 1, 7, 0, 1), 0, 1, 1, s, 3);
        add(mk(0, 1, 0, 0, 0, 0, 1, 7, 0, 0), 0, 1, 0, s, 4);
        add(mk(0, 1, 7, 0, 1, 0, 0, 0, 0, 0), 0, 0, 0, s, 4);
        // hazard and redirect in the same cycle
        add(mk(0, 1, 0, 0, 0, 0, 1, 9, 1, 0), 0, 0, 1, s, 4);
        add(mk(0, 1, 0, 9, 0, 1, 0, 0, 0, 1), 0, 1, 1, s, 5);
        add(idle, 0, 1, 1, s, 6);
        add(idle, 0, 0, 0, s, 6);
        // reset while flushing, with live inputs
        add(pcw, 0, 1, 1, s, 7);
        add(mk(1, 1, 0, 0, 0, 0, 1, 2, 0, 1), 0, 0, 0, 0, 0);
        add(idle, 0, 0, 0, 0, 0);
        // redirect during flush restarts it
        add(pcw, 0, 1, 1, 0, 1);
        add(pcw, 0, 1, 1, 0, 2);
        add(idle, 0, 1, 0, 0, 3);
        add(idle, 0, 0, 0, 0, 3);

        foreach (vt[i]) begin
            drive(vt[i].in);
            tg = $sformatf("vec%0d", i);
            chk({tg, " ctl"}, 32'(o_ctl),
                32'({vt[i].e_stall, vt[i].e_stall,
                     vt[i].e_flush, vt[i].e_flush}));
            chk({tg, " busy"}, 32'(r_busy), 32'(vt[i].e_busy));
            chk({tg, " stall_count"}, 32'(r_scnt), 32'(vt[i].e_scnt));
            chk({tg, " flush_count"}, 32'(r_fcnt), 32'(vt[i].e_fcnt));
        end

        // counter saturation: repeated load then three dependent reads
        wr1 = mk(0, 1, 0, 0, 0, 0, 1, 1, 1, 0);
        rd1 = mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cmp_model("sat reset");
        for (int n = 0; n < 300; n++) begin
            drive(wr1);
            cmp_model($sformatf("sat%0d w", n));
            for (int k = 0; k < 3; k++) begin
                drive(rd1);
                cmp_model($sformatf("sat%0d r%0d", n, k));
            end
        end
        chk("sat narrow stall_count", 32'(r_sat), 32'hFF);
        chk("sat wide stall_count", 32'(r_scnt), FWD ? 300 : 900);

        // randomized traffic against the model
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cmp_model("rnd reset");
        for (int n = 0; n < 4000; n++) begin
            ri = mk($urandom_range(299) == 0,
                    $urandom_range(3) != 0,
                    $urandom_range(3), $urandom_range(3),
                    $urandom_range(1), $urandom_range(1),
                    $urandom_range(1), $urandom_range(3),
                    $urandom_range(1),
                    $urandom_range(7) == 0);
            drive(ri);
            cmp_model($sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
